// File: rtl/sda_kernel_ctrl_irq_reg_if.sv
// Register-bus interface for sda_kernel_ctrl_irq_reg: request/ack handshake with
// OR-able read data (zero whenever regAck is low).
interface sda_kernel_ctrl_irq_reg_if #(
  parameter int RegAddrWidth = 8
);
  logic                    regReq;
  logic                    regAck;
  logic                    regWriteEn;
  logic [RegAddrWidth-1:0] regAddr;
  logic [31:0]             regWData;
  logic [31:0]             regRData;

  modport master (
    output regReq, regWriteEn, regAddr, regWData,
    input  regAck, regRData
  );

  modport slave (
    input  regReq, regWriteEn, regAddr, regWData,
    output regAck, regRData
  );
endinterface

// File: rtl/sda_kernel_ctrl_irq_reg.sv
// Kernel control/interrupt register block (CTRL, GIE, IER, ISR) with go/done handshake.
// Optional auto-restart is enabled by defining SDA_KERNEL_CTRL_AUTO_RESTART_EN.
module sda_kernel_ctrl_irq_reg #(
  parameter int RegAddrWidth = 8,
  parameter int RegBaseAddr  = 0
) (
  input  logic                           clk,
  input  logic                           srst,
  sda_kernel_ctrl_irq_reg_if.slave       bus,
  output logic                           goValid,
  input  logic                           goHoldoff,
  input  logic                           doneValid,
  output logic                           doneStop,
  output logic                           irq
);

  localparam logic [3:0] OffCtrl = 4'h0;
  localparam logic [3:0] OffGie  = 4'h4;
  localparam logic [3:0] OffIer  = 4'h8;
  localparam logic [3:0] OffIsr  = 4'hC;
  localparam logic [RegAddrWidth-1:0] BaseAddr = RegAddrWidth'(RegBaseAddr);

  logic                    req_q, req_d;
  logic                    we_q;
  logic [RegAddrWidth-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic                    ack_q, ack_d;
  logic [31:0]             rdata_q, rdata_d;

  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       idle_q, idle_d;
  logic       ready_q, ready_d;
  logic       go_q, go_d;
  logic       gie_q, gie_d;
  logic [1:0] ier_q, ier_d;
  logic [1:0] isr_q, isr_d;
  logic       irq_q, irq_d;

  logic        mapped_s;
  logic        wr_ctrl_s, rd_ctrl_s, wr_gie_s, wr_ier_s, wr_isr_s;
  logic        go_hs_s, done_ev_s;
  logic        auto_restart_s;
  logic [31:0] read_val_s;
  logic        unused_ok_s;

`ifdef SDA_KERNEL_CTRL_AUTO_RESTART_EN
  logic auto_restart_q, auto_restart_d;

  assign auto_restart_d = wr_ctrl_s ? wdata_q[7] : auto_restart_q;
  assign auto_restart_s = auto_restart_q;
  assign unused_ok_s    = ^{wdata_q[31:8], wdata_q[6:2]};

  // Auto-restart flag, loaded by every CTRL write.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      auto_restart_q <= 1'b0;
    end else begin
      auto_restart_q <= auto_restart_d;
    end
  end
`else
  assign auto_restart_s = 1'b0;
  assign unused_ok_s    = ^{wdata_q[31:2]};
`endif

  // Address decode, access strobes and register next-state logic.
  always_comb begin
    mapped_s = 1'b0;
    if (addr_q[RegAddrWidth-1:4] == BaseAddr[RegAddrWidth-1:4]) begin
      case (addr_q[3:0])
        OffCtrl, OffGie, OffIer, OffIsr: mapped_s = 1'b1;
        default:                         mapped_s = 1'b0;
      endcase
    end else begin
      mapped_s = 1'b0;
    end

    ack_d = req_q & mapped_s;
    // New requests are dropped while an access is still in flight.
    req_d = bus.regReq & ~ack_q & ~ack_d;

    wr_ctrl_s = ack_d &  we_q & (addr_q[3:0] == OffCtrl);
    rd_ctrl_s = ack_d & ~we_q & (addr_q[3:0] == OffCtrl);
    wr_gie_s  = ack_d &  we_q & (addr_q[3:0] == OffGie);
    wr_ier_s  = ack_d &  we_q & (addr_q[3:0] == OffIer);
    wr_isr_s  = ack_d &  we_q & (addr_q[3:0] == OffIsr);

    go_hs_s   = go_q & ~goHoldoff;
    done_ev_s = ~idle_q & doneValid;

    case (addr_q[3:0])
      OffCtrl: read_val_s = {24'h0, auto_restart_s, 3'b000, ready_q, idle_q, done_q, start_q};
      OffGie:  read_val_s = {31'h0, gie_q};
      OffIer:  read_val_s = {30'h0, ier_q};
      OffIsr:  read_val_s = {30'h0, isr_q};
      default: read_val_s = 32'h0;
    endcase
    rdata_d = (ack_d & ~we_q) ? read_val_s : 32'h0;

    // Later assignments take priority: host start write beats the go clear.
    start_d = start_q;
    if (go_hs_s) begin
      start_d = 1'b0;
    end else begin
      start_d = start_d;
    end
    if (done_ev_s & auto_restart_s) begin
      start_d = 1'b1;
    end else begin
      start_d = start_d;
    end
    if (wr_ctrl_s & wdata_q[0]) begin
      start_d = 1'b1;
    end else begin
      start_d = start_d;
    end

    done_d = done_q;
    if (rd_ctrl_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_d;
    end
    if (done_ev_s) begin
      done_d = 1'b1;
    end else begin
      done_d = done_d;
    end

    if (go_hs_s) begin
      idle_d = 1'b0;
    end else if (done_ev_s) begin
      idle_d = 1'b1;
    end else begin
      idle_d = idle_q;
    end

    ready_d = go_hs_s ? 1'b0 : (idle_q & ~goHoldoff);

    if (go_hs_s) begin
      go_d = 1'b0;
    end else if (start_q & ready_q) begin
      go_d = 1'b1;
    end else begin
      go_d = go_q;
    end

    gie_d = wr_gie_s ? wdata_q[0]   : gie_q;
    ier_d = wr_ier_s ? wdata_q[1:0] : ier_q;
    isr_d = (isr_q ^ (wr_isr_s ? wdata_q[1:0] : 2'b00)) | {go_hs_s, done_ev_s};
    irq_d = gie_q & |(isr_q & ier_q);
  end

  // Bus pipeline and control/status state.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      ready_q <= 1'b0;
      go_q    <= 1'b0;
      gie_q   <= 1'b0;
      ier_q   <= 2'b00;
      isr_q   <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= bus.regWriteEn;
      addr_q  <= bus.regAddr;
      wdata_q <= bus.regWData;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
      go_q    <= go_d;
      gie_q   <= gie_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.regAck   = ack_q;
  assign bus.regRData = rdata_q;
  assign goValid      = go_q;
  assign doneStop     = idle_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_sda_kernel_ctrl_irq_reg.sv
// Directed bench for sda_kernel_ctrl_irq_reg; covers the auto-restart path when
// SDA_KERNEL_CTRL_AUTO_RESTART_EN is defined, the tied-off bit 7 otherwise.
module tb_sda_kernel_ctrl_irq_reg;
  logic clk = 1'b0;
  logic srst;
  logic goHoldoff;
  logic doneValid;
  logic goValid;
  logic doneStop;
  logic irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  int go_cnt = 0;
  int lat;
  int g0;
  logic [31:0] rd;

  sda_kernel_ctrl_irq_reg_if #(.RegAddrWidth(8)) bus ();

  sda_kernel_ctrl_irq_reg #(.RegAddrWidth(8), .RegBaseAddr(0)) dut (
    .clk       (clk),
    .srst      (srst),
    .bus       (bus),
    .goValid   (goValid),
    .goHoldoff (goHoldoff),
    .doneValid (doneValid),
    .doneStop  (doneStop),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (goValid && !goHoldoff) go_cnt <= go_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One access; lat = cycles from request cycle to ack (0 = no ack within 4 cycles).
  task automatic bus_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            output int l, output logic [31:0] r);
    l = 0;
    r = 32'h0;
    @(negedge clk);
    bus.regReq = 1'b1; bus.regWriteEn = we; bus.regAddr = addr; bus.regWData = wd;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.regReq = 1'b0;
      if (bus.regAck === 1'b1 && l == 0) begin
        l = i;
        r = bus.regRData;
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk) doneValid = 1'b1;
    @(negedge clk) doneValid = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; goHoldoff = 1'b1; doneValid = 1'b0;
    bus.regReq = 1'b0; bus.regWriteEn = 1'b0; bus.regAddr = 8'h00; bus.regWData = 32'h0;
    tick(2);
    total_cnt++; if (goValid !== 1'b0) $display("FAIL rst_goValid: got %b want 0", goValid); else pass_cnt++;
    total_cnt++; if (doneStop !== 1'b1) $display("FAIL rst_doneStop: got %b want 1", doneStop); else pass_cnt++;
    total_cnt++; if (bus.regAck !== 1'b0) $display("FAIL rst_regAck: got %b want 0", bus.regAck); else pass_cnt++;
    total_cnt++; if (bus.regRData !== 32'h0) $display("FAIL rst_regRData: got %h want 0", bus.regRData); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else pass_cnt++;
    srst = 1'b0;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (lat !== 2) $display("FAIL rst_ack_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h4) $display("FAIL rst_ctrl_read: got %h want 00000004", rd); else pass_cnt++;
    goHoldoff = 1'b0;
    tick(1);
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hC) $display("FAIL rst_ctrl_ready: got %h want 0000000c", rd); else pass_cnt++;
  endtask

  task automatic test_kernel_run();
    g0 = go_cnt;
    bus_access(1'b1, 8'h00, 32'h1, lat, rd);
    total_cnt++; if (lat !== 2) $display("FAIL run_write_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (go_cnt - g0 !== 1) $display("FAIL run_go_count: got %0d want 1", go_cnt - g0); else pass_cnt++;
    total_cnt++; if (goValid !== 1'b0) $display("FAIL run_go_cleared: got %b want 0", goValid); else pass_cnt++;
    total_cnt++; if (doneStop !== 1'b0) $display("FAIL run_busy_doneStop: got %b want 0", doneStop); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL run_ctrl_busy: got %h want 0", rd); else pass_cnt++;
    pulse_done();
    total_cnt++; if (doneStop !== 1'b1) $display("FAIL run_done_doneStop: got %b want 1", doneStop); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hE) $display("FAIL run_ctrl_done: got %h want 0000000e", rd); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hC) $display("FAIL run_ctrl_cleared: got %h want 0000000c", rd); else pass_cnt++;
    bus_access(1'b0, 8'h0C, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h3) $display("FAIL run_isr: got %h want 00000003", rd); else pass_cnt++;
    bus_access(1'b1, 8'h0C, 32'h3, lat, rd);
    bus_access(1'b0, 8'h0C, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL run_isr_toggled: got %h want 0", rd); else pass_cnt++;
  endtask

  task automatic test_irq();
    bus_access(1'b1, 8'h04, 32'h1, lat, rd);
    bus_access(1'b1, 8'h08, 32'h1, lat, rd);
    bus_access(1'b1, 8'h00, 32'h1, lat, rd);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_ready_masked: got %b want 0", irq); else pass_cnt++;
    pulse_done();
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_not_early: got %b want 0", irq); else pass_cnt++;
    tick(1);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_done_raised: got %b want 1", irq); else pass_cnt++;
    bus_access(1'b1, 8'h0C, 32'h1, lat, rd);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_isr_clear: got %b want 0", irq); else pass_cnt++;
    bus_access(1'b1, 8'h08, 32'h3, lat, rd);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_ready_enabled: got %b want 1", irq); else pass_cnt++;
    bus_access(1'b1, 8'h0C, 32'h2, lat, rd);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_ready_clear: got %b want 0", irq); else pass_cnt++;
    bus_access(1'b1, 8'h0C, 32'h1, lat, rd);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_toggle_sets: got %b want 1", irq); else pass_cnt++;
    bus_access(1'b1, 8'h0C, 32'h1, lat, rd);
    bus_access(1'b1, 8'h04, 32'h0, lat, rd);
    bus_access(1'b1, 8'h08, 32'h0, lat, rd);
    bus_access(1'b0, 8'h0C, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL irq_isr_final: got %h want 0", rd); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
  endtask

  task automatic test_boundary();
    g0 = go_cnt;
    bus_access(1'b1, 8'h10, 32'h1, lat, rd);
    total_cnt++; if (lat !== 0) $display("FAIL bnd_unmapped_ack: got %0d want 0", lat); else pass_cnt++;
    tick(4);
    total_cnt++; if (go_cnt - g0 !== 0) $display("FAIL bnd_unmapped_effect: got %0d want 0", go_cnt - g0); else pass_cnt++;
    bus_access(1'b0, 8'h02, 32'h0, lat, rd);
    total_cnt++; if (lat !== 0) $display("FAIL bnd_offset2_ack: got %0d want 0", lat); else pass_cnt++;
    bus_access(1'b1, 8'h04, 32'hFFFF_FFFF, lat, rd);
    bus_access(1'b0, 8'h04, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h1) $display("FAIL bnd_gie_width: got %h want 00000001", rd); else pass_cnt++;
    bus_access(1'b1, 8'h04, 32'h0, lat, rd);
    pulse_done();
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hC) $display("FAIL bnd_done_while_idle: got %h want 0000000c", rd); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    bus_access(1'b1, 8'h00, 32'h1, lat, rd);
    @(negedge clk); bus.regReq = 1'b1; bus.regWriteEn = 1'b0; bus.regAddr = 8'h00;
    @(negedge clk); bus.regReq = 1'b0; doneValid = 1'b1;
    @(negedge clk); doneValid = 1'b0;
    total_cnt++; if (bus.regAck !== 1'b1 || bus.regRData !== 32'h0)
      $display("FAIL same_read_done_ack: got ack %b data %h want ack 1 data 0", bus.regAck, bus.regRData); else pass_cnt++;
    tick(1);
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hE) $display("FAIL same_done_wins: got %h want 0000000e", rd); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    // Launch with goValid left pending under backpressure.
    g0 = go_cnt;
    @(negedge clk); bus.regReq = 1'b1; bus.regWriteEn = 1'b1; bus.regAddr = 8'h00; bus.regWData = 32'h1;
    @(negedge clk); bus.regReq = 1'b0;
    @(negedge clk); goHoldoff = 1'b1;
    tick(3);
    total_cnt++; if (goValid !== 1'b1) $display("FAIL same_go_held: got %b want 1", goValid); else pass_cnt++;
    @(negedge clk); bus.regReq = 1'b1;
    @(negedge clk); bus.regReq = 1'b0; goHoldoff = 1'b0;
    tick(3);
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h1) $display("FAIL same_start_kept: got %h want 00000001", rd); else pass_cnt++;
    pulse_done();
    tick(6);
    total_cnt++; if (go_cnt - g0 !== 2) $display("FAIL same_relaunch_once: got %0d want 2", go_cnt - g0); else pass_cnt++;
    pulse_done();
    tick(6);
    total_cnt++; if (go_cnt - g0 !== 2) $display("FAIL same_no_third_go: got %0d want 2", go_cnt - g0); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    bus_access(1'b0, 8'h0C, 32'h0, lat, rd);
    bus_access(1'b1, 8'h0C, rd, lat, rd);
  endtask

  task automatic test_auto_restart();
    g0 = go_cnt;
`ifdef SDA_KERNEL_CTRL_AUTO_RESTART_EN
    bus_access(1'b1, 8'h00, 32'h81, lat, rd);
    pulse_done();
    tick(6);
    pulse_done();
    tick(6);
    total_cnt++; if (go_cnt - g0 !== 3) $display("FAIL auto_relaunch_twice: got %0d want 3", go_cnt - g0); else pass_cnt++;
    bus_access(1'b1, 8'h00, 32'h0, lat, rd);
    pulse_done();
    tick(6);
    total_cnt++; if (go_cnt - g0 !== 3) $display("FAIL auto_stopped: got %0d want 3", go_cnt - g0); else pass_cnt++;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hE) $display("FAIL auto_ctrl_done: got %h want 0000000e", rd); else pass_cnt++;
`else
    bus_access(1'b1, 8'h00, 32'h80, lat, rd);
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'hC) $display("FAIL noauto_bit7: got %h want 0000000c", rd); else pass_cnt++;
    tick(4);
    total_cnt++; if (go_cnt - g0 !== 0) $display("FAIL noauto_no_go: got %0d want 0", go_cnt - g0); else pass_cnt++;
`endif
    bus_access(1'b0, 8'h0C, 32'h0, lat, rd);
    bus_access(1'b1, 8'h0C, rd, lat, rd);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.regReq = 1'b1; bus.regWriteEn = 1'b1; bus.regAddr = 8'h00; bus.regWData = 32'h1;
    @(negedge clk); bus.regReq = 1'b0;
    @(negedge clk); goHoldoff = 1'b1;
    tick(2);
    total_cnt++; if (goValid !== 1'b1) $display("FAIL mid_go_pending: got %b want 1", goValid); else pass_cnt++;
    @(negedge clk); bus.regReq = 1'b1; bus.regWriteEn = 1'b0; bus.regAddr = 8'h00;
    @(negedge clk); bus.regReq = 1'b0; srst = 1'b1;
    #1;
    total_cnt++; if (goValid !== 1'b0 || doneStop !== 1'b1 || irq !== 1'b0)
      $display("FAIL mid_rst_outputs: got go %b stop %b irq %b want 0 1 0", goValid, doneStop, irq); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.regAck !== 1'b0 || bus.regRData !== 32'h0)
      $display("FAIL mid_rst_ack_aborted: got ack %b data %h want 0 0", bus.regAck, bus.regRData); else pass_cnt++;
    srst = 1'b0;
    bus_access(1'b0, 8'h00, 32'h0, lat, rd);
    total_cnt++; if (rd !== 32'h4) $display("FAIL mid_ctrl_after: got %h want 00000004", rd); else pass_cnt++;
    goHoldoff = 1'b0;
  endtask

  initial begin
    test_reset();
    test_kernel_run();
    test_irq();
    test_boundary();
    test_same_cycle();
    test_auto_restart();
    test_reset_mid();
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sda_kernel_ctrl_irq_reg.md
SDA_KERNEL_CTRL_IRQ_REG -- requirements
Module: sda_kernel_ctrl_irq_reg

Interface
REQ-001 SHALL have parameter RegAddrWidth, default 8: register address bus width in bits, minimum 4.
REQ-002 SHALL have parameter RegBaseAddr, default 0: base offset of the 16-byte register window, aligned to 16.
REQ-003 clk  input  1  system clock; one clock, all state on the rising edge.
REQ-004 srst  input  1  reset, asynchronous and active-high.
REQ-005 regReq  input  1  register access request.
REQ-006 regAck  output  1  access acknowledge, a single-cycle pulse.
REQ-007 regWriteEn  input  1  1 = write, 0 = read.
REQ-008 regAddr  input  RegAddrWidth  byte address.
REQ-009 regWData  input  32  write data.
REQ-010 regRData  output  32  read data; zero whenever regAck is 0, so it can be ORed with other register blocks.
REQ-011 goValid  output  1  kernel go request.
REQ-012 goHoldoff  input  1  kernel go backpressure.
REQ-013 doneValid  input  1  kernel completion.
REQ-014 doneStop  output  1  done backpressure; equals the idle bit.
REQ-015 irq  output  1  level interrupt, registered.

Function
REQ-016 SHALL register regReq, regWriteEn, regAddr and regWData in the cycle after sampling; regReq is gated by ~regAck_q & ~regAck_d, so back-to-back requests are ignored until the ack completes.
REQ-017 SHALL decode four registers at these offsets from RegBaseAddr:
- CTRL 0x0: start bit 0 (R/W1S), done bit 1 (read-clear), idle bit 2, ready bit 3, autoRestart bit 7 (R/W).
- GIE 0x4: bit 0.
- IER 0x8: bit 0 = done, bit 1 = ready.
- ISR 0xC: bits 0 and 1, toggle-on-write-1.
REQ-018 SHALL assert regAck exactly 2 cycles after a mapped request is sampled, for one cycle, for both reads and writes; unmapped addresses get no ack and no side effect.
REQ-019 SHALL zero every regRData bit that REQ-017 does not define.
REQ-020 A CTRL write with bit 0 = 1 SHALL set start; writing 0 to bit 0 has no effect.
REQ-021 A CTRL write SHALL always load autoRestart from bit 7.
REQ-022 ready_d SHALL equal idle_q & ~goHoldoff.
REQ-023 While start_q & ready_q, goValid SHALL be set.
REQ-024 On goValid_q & ~goHoldoff (go handshake), the next state SHALL clear start, idle, ready and goValid, and set ISR[1].
REQ-025 When ~idle_q & doneValid (done event), the next state SHALL set done and idle and set ISR[0].
REQ-026 If autoRestart_q = 1 at a done event, start SHALL also be set.
REQ-027 A CTRL read SHALL clear done; a done event in the same cycle wins and done stays 1.
REQ-028 A host start write in the same cycle as a go handshake SHALL leave start = 1, so the kernel relaunches once.
REQ-029 An ISR toggle in the same cycle as the set event for that bit SHALL leave the bit at 1.
REQ-030 irq SHALL be registered from GIE & |(ISR & IER), one cycle after the cause.
REQ-031 doneValid while idle_q = 1 SHALL be ignored.

Reset
REQ-032 SHALL asynchronously reset all state: idle = 1; start, done, ready, goValid, autoRestart, GIE, IER, ISR and all pipeline registers = 0.
REQ-033 Output reset values SHALL be: goValid = 0, doneStop = 1, regAck = 0, regRData = 0, irq = 0.
REQ-034 Reset asserted mid-operation SHALL abort any pending ack and any outstanding go.

Configuration
REQ-035 With macro SDA_KERNEL_CTRL_AUTO_RESTART_EN defined, SHALL implement autoRestart as specified.
REQ-036 With SDA_KERNEL_CTRL_AUTO_RESTART_EN undefined, autoRestart SHALL be constant 0, CTRL bit 7 SHALL read 0, and writes to bit 7 SHALL be ignored.

Verification
REQ-037 After reset, read CTRL -> regAck 2 cycles later; regRData = 0x00000004 (0x0000000C once goHoldoff = 0 has been sampled).
REQ-038 Write CTRL = 0x1 with goHoldoff = 0 -> goValid pulses, then CTRL reads 0x0; doneValid -> doneStop = 1 and CTRL reads 0xE; the next read returns 0xC.
REQ-039 Write GIE = 1 and IER = 0x1, then run a kernel -> irq = 1 one cycle after ISR[0] sets; write ISR = 0x1 -> irq = 0.
REQ-040 With the macro defined, write CTRL = 0x81 and pulse doneValid -> goValid re-asserts without any further host write, twice in a row.
REQ-041 Read CTRL in the same cycle as a done event -> done reads 1 on the following read; a request at 0x10 -> no ack.
REQ-042 Assert srst while goValid = 1 and an ack is pending -> all outputs return to reset values immediately.
